// File: rtl/host_tx_packet_sequencer.sv
// Host TX sequencer: validates a host command, frames it as HDR/CMD/PAYLOAD[/TAIL] 16-bit beats, optional LFSR OTP on payload.
// Latency: header valid 2 cycles after command accept; done pulses the cycle after the last beat is accepted.
// Backpressure: out_valid/out_ready; beats and keystream hold while stalled; cmd_ready only in IDLE (no queueing).
// Optional feature macro: HOST_TX_CRC_EN appends a CRC-16-CCITT tail beat.
module host_tx_packet_sequencer #(
  parameter int          WORDS_MAX = 8,
  parameter logic [15:0] KEY_SEED  = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [15:0]              cmd,
  input  logic [7:0]               payload_len,
  input  logic [16*WORDS_MAX-1:0]  payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              out_data,
  output logic                     out_last,
  output logic                     done,
  output logic                     error,
  output logic                     enc_en
);

  localparam logic [3:0]  TX_OPCODE = 4'h1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [7:0]  LEN_MAX   = 8'(WORDS_MAX);
  localparam logic [15:0] CMD_ENC_ON  = 16'h0001;
  localparam logic [15:0] CMD_ENC_OFF = 16'h0002;
  localparam logic [15:0] CMD_SEND    = 16'h0003;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_HDR, S_CMD, S_PAYLOAD, S_TAIL, S_DONE
  } state_t;

`ifdef HOST_TX_CRC_EN
  localparam bit     CRC_EN    = 1'b1;
  localparam state_t END_STATE = S_TAIL;
`else
  localparam bit     CRC_EN    = 1'b0;
  localparam state_t END_STATE = S_DONE;
`endif

  // Galois LFSR, shift right, feedback applied when the outgoing bit is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

`ifdef HOST_TX_CRC_EN
  // CRC-16-CCITT over one 16-bit word, MSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      if (r[15] ^ w[b]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  state_t                  state_q, state_d;
  logic [15:0]             cmd_q, cmd_d;
  logic [7:0]              len_q, len_d;
  logic [16*WORDS_MAX-1:0] payload_q, payload_d;
  logic [7:0]              idx_q, idx_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic                    enc_q, enc_d;
`ifdef HOST_TX_CRC_EN
  logic [15:0]             crc_q, crc_d;
`endif

  logic [15:0] cur_word;
  logic [15:0] key;
  logic        cmd_ok;
  logic        last_word;

  // Select the payload word addressed by the beat index.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < WORDS_MAX; i++) begin
      if (idx_q == 8'(i)) cur_word = payload_q[i*16 +: 16];
    end
  end

  // Command validation and keystream derived from latched registers only, so beats hold during stalls.
  always_comb begin
    key       = enc_q ? lfsr_q : 16'h0000;
    last_word = (idx_q == (len_q - 8'd1));
    cmd_ok    = (((cmd_q == CMD_ENC_ON) || (cmd_q == CMD_ENC_OFF)) && (len_q == 8'd0)) ||
                ((cmd_q == CMD_SEND) && (len_q != 8'd0) && (len_q <= LEN_MAX));
  end

  // Next-state, datapath updates and Moore outputs.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    lfsr_d    = lfsr_q;
    enc_d     = enc_q;
`ifdef HOST_TX_CRC_EN
    crc_d     = crc_q;
`endif
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = 16'h0000;
    out_last  = 1'b0;
    done      = 1'b0;
    error     = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_d     = cmd;
          len_d     = payload_len;
          payload_d = payload;
          idx_d     = 8'd0;
`ifdef HOST_TX_CRC_EN
          crc_d     = 16'hFFFF;
`endif
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_ok) begin
          state_d = S_HDR;
        end else begin
          error   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        out_valid = 1'b1;
        out_data  = {TX_OPCODE, 4'h0, len_q};
        if (out_ready) state_d = S_CMD;
      end
      S_CMD: begin
        out_valid = 1'b1;
        out_data  = cmd_q;
        out_last  = (len_q == 8'd0) && !CRC_EN;
        if (out_ready) state_d = (len_q != 8'd0) ? S_PAYLOAD : END_STATE;
      end
      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = cur_word ^ key;
        out_last  = last_word && !CRC_EN;
        if (out_ready) begin
          if (enc_q) lfsr_d = lfsr_step(lfsr_q);
          if (last_word) state_d = END_STATE;
          else           idx_d   = idx_q + 8'd1;
        end
      end
`ifdef HOST_TX_CRC_EN
      S_TAIL: begin
        out_valid = 1'b1;
        out_data  = crc_q;
        out_last  = 1'b1;
        if (out_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
        if (cmd_q == CMD_ENC_ON) begin
          enc_d  = 1'b1;
          lfsr_d = KEY_SEED;
        end else if (cmd_q == CMD_ENC_OFF) begin
          enc_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HOST_TX_CRC_EN
    // CRC accumulates every accepted beat before the tail.
    if (out_valid && out_ready && (state_q != S_TAIL)) crc_d = crc_step(crc_q, out_data);
`endif
  end

  assign enc_en = enc_q;

  // State and datapath registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      len_q     <= '0;
      payload_q <= '0;
      idx_q     <= '0;
      lfsr_q    <= KEY_SEED;
      enc_q     <= 1'b0;
`ifdef HOST_TX_CRC_EN
      crc_q     <= 16'hFFFF;
`endif
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      lfsr_q    <= lfsr_d;
      enc_q     <= enc_d;
`ifdef HOST_TX_CRC_EN
      crc_q     <= crc_d;
`endif
    end
  end

endmodule

// File: doc/host_tx_packet_sequencer.md
# host_tx_packet_sequencer

Parametrised host-to-radio transmit sequencer. It accepts a host command with up to `WORDS_MAX` 16-bit payload words and validates it. It applies one-time-pad (LFSR keystream XOR) encryption when encryption mode is on, and streams a framed packet of 16-bit beats to the Bluetooth encoder over a valid/ready handshake. It sits between the UART command decoder and the BLE encoder. It generalises the single-word, single-command transmit path to variable-length payloads with backpressure.

## Interface
- `WORDS_MAX`, 8: maximum payload words per packet (1..255).
- `KEY_SEED`, 16'hACE1: LFSR keystream seed; must be non-zero.
- `clk  in  1`: clock, rising edge.
- `reset_n  in  1`: asynchronous, active-low reset.
- `cmd_valid  in  1`: command offered.
- `cmd_ready  out  1`: sequencer can accept a command.
- `cmd  in  16`: command code.
- `payload_len  in  8`: number of payload words.
- `payload  in  16*WORDS_MAX`: payload words; word i is `[16i+15:16i]`, and word 0 is sent first.
- `out_valid  out  1`: output beat valid.
- `out_ready  in  1`: encoder accepts beat.
- `out_data  out  16`: output beat.
- `out_last  out  1`: final beat of packet.
- `done  out  1`: one-cycle pulse when a packet completes.
- `error  out  1`: one-cycle pulse when a command is rejected.
- `enc_en  out  1`: current encryption mode.

## Operation
- Commands:
  - 16'h0001: encryption enable; `payload_len` must be 0.
  - 16'h0002: encryption disable; `payload_len` must be 0.
  - 16'h0003: data send; `1 <= payload_len <= WORDS_MAX`.
  - Any other code, or a length violation, is rejected.
- States:
  - IDLE: `cmd_ready=1`. On `cmd_valid`, latch `cmd`, `payload_len` and `payload`, then go to CHECK.
  - CHECK: one cycle. If invalid, pulse `error` and return to IDLE. If valid, go to HDR.
  - HDR: drive beat `{4'h1, 4'h0, len[7:0]}`, where 4'h1 is the TX opcode. Go to CMD on accept.
  - CMD: drive beat `cmd`. Go to PAYLOAD on accept if len>0; otherwise go to TAIL/DONE.
  - PAYLOAD: drive one beat per word, in order. Go to TAIL/DONE after the last word is accepted.
  - TAIL: exists only with `HOST_TX_CRC_EN`. Drive the CRC beat.
  - DONE: one cycle. Pulse `done`, apply any mode change, return to IDLE.
- Encryption, applied only to payload words:
  - If `enc_en=1`: beat = word XOR key, where key is the current 16-bit Galois LFSR state (mask 16'hB400, shift right). The LFSR advances once per accepted payload beat.
  - If `enc_en=0`: words pass unchanged and the LFSR does not advance.
- Mode change:
  - Commands 0x1 and 0x2 update `enc_en` in DONE, so their own packet is framed under the old mode.
  - Command 0x1 also reloads the LFSR to `KEY_SEED` in DONE.
- Beat hold: `out_data` and `out_last` stay stable while `out_valid=1` and `out_ready=0`. The key is computed from the LFSR state and does not change during a stall.
- `out_last` is 1 on the final beat only: CMD when len=0 without CRC, the last PAYLOAD beat without CRC, or TAIL with CRC.
- Rejected commands emit no beats and do not change `enc_en` or the LFSR.

## Timing
- Reset values (async assert, released synchronously to `clk`):
  - state IDLE, `cmd_ready=1`.
  - `out_valid=0`, `out_data=0`, `out_last=0`.
  - `done=0`, `error=0`.
  - `enc_en=0`, LFSR=`KEY_SEED`.
- Command accept edge is N:
  - `cmd_ready=0` from N+1.
  - CHECK occupies N+1.
  - `error` pulses high in cycle N+1 for a rejected command.
  - The header is valid from N+2.
- With `out_ready` held high, one beat is transferred per cycle.
  - Data packet: N+2 .. N+3+len. `done` pulses in N+4+len, and `cmd_ready=1` in N+5+len.
  - With CRC, every figure after the payload shifts by +1.
- `cmd_valid` outside IDLE is ignored; the command is not queued.
- `reset_n` asserted mid-packet:
  - Immediately drops `out_valid` and aborts the packet.
  - Clears `enc_en`; no partial packet resumes.

## Configuration
- `HOST_TX_CRC_EN` defined:
  - A TAIL beat is appended after the payload (or after CMD when len=0).
  - TAIL carries CRC-16-CCITT: polynomial 16'h1021, init 16'hFFFF, MSB-first, no final XOR.
  - The CRC covers every transmitted beat from HDR through the last payload beat, post-encryption.
  - Header `len` still counts payload words only.
- `HOST_TX_CRC_EN` undefined: no TAIL state; the packet ends at CMD or the last payload beat.

## Test plan
- Reset, then command 0x3, len 2, payload {16'h1234, 16'hABCD}, `enc_en=0`, `out_ready=1` → beats 16'h1002, 16'h0003, 16'h1234, 16'hABCD (`out_last` on the fourth); `done` pulses at N+6.
- Command 0x1 (len 0), then command 0x3, len 1, word 16'h0000 → `enc_en=1` after the first packet; second packet's payload beat = 16'hACE1 (key equals seed).
- Command 0x3 with len 0, then with len `WORDS_MAX`+1, then command 16'h0007 → each produces an `error` pulse in N+1, no `out_valid`, and no `enc_en` change.
- Data packet with `out_ready` toggled every other cycle, encryption on → beats identical to the stall-free run, each held stable while stalled, LFSR advancing exactly once per payload beat.
- Assert `reset_n` during the second payload beat → `out_valid=0` immediately, `enc_en=0`; the next command runs from the header with the LFSR at `KEY_SEED`.
- With `HOST_TX_CRC_EN`, command 0x2 → beats 16'h1000, 16'h0002, then CRC over {16'h1000, 16'h0002} with `out_last` set; bench compares the CRC against the reference model.
